// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop input synchronizer, mid-bit sampling FSM and
// registered word/strobe outputs. A low stop bit parks the FSM until the line returns high.
module uart_rx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 din,
    output logic [DATA_BITS-1:0] dout,
    output logic                 rx_done,
    output logic                 frame_err,
    output logic                 busy
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

    state_t               state_reg, state_next;
    logic [1:0]           sync_reg;
    logic                 din_s;
    logic [CW-1:0]        cnt_reg, cnt_next;
    logic [IW-1:0]        bit_idx_reg, bit_idx_next;
    logic [DATA_BITS-1:0] shift_reg, shift_next;
    logic [DATA_BITS-1:0] dout_reg, dout_next;
    logic                 rx_done_reg, rx_done_next;
    logic                 frame_err_reg, frame_err_next;

    assign din_s = sync_reg[1];

    // Synchronizer presets high so reset looks like an idle line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_reg      <= 2'b11;
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            bit_idx_reg   <= '0;
            shift_reg     <= '0;
            dout_reg      <= '0;
            rx_done_reg   <= 1'b0;
            frame_err_reg <= 1'b0;
        end else begin
            sync_reg      <= {sync_reg[0], din};
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            bit_idx_reg   <= bit_idx_next;
            shift_reg     <= shift_next;
            dout_reg      <= dout_next;
            rx_done_reg   <= rx_done_next;
            frame_err_reg <= frame_err_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:  if (!din_s) state_next = START;
            START: if (cnt_reg == CNT_HALF) state_next = din_s ? IDLE : DATA;
            DATA:  if (cnt_reg == CNT_LAST && bit_idx_reg == IDX_LAST) state_next = STOP;
            STOP:  if (cnt_reg == CNT_LAST) state_next = din_s ? IDLE : BREAK;
            BREAK: if (din_s) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        cnt_next       = '0;
        bit_idx_next   = bit_idx_reg;
        shift_next     = shift_reg;
        dout_next      = dout_reg;
        rx_done_next   = 1'b0;
        frame_err_next = 1'b0;
        case (state_reg)
            START: begin
                cnt_next = cnt_reg + CW'(1);
                if (cnt_reg == CNT_HALF) begin
                    cnt_next     = '0;
                    bit_idx_next = '0;
                end
            end
            DATA: begin
                cnt_next = cnt_reg + CW'(1);
                if (cnt_reg == CNT_LAST) begin
                    // Right shift: the first bit received ends up in bit 0.
                    cnt_next     = '0;
                    shift_next   = {din_s, shift_reg[DATA_BITS-1:1]};
                    bit_idx_next = bit_idx_reg + IW'(1);
                end
            end
            STOP: begin
                cnt_next = cnt_reg + CW'(1);
                if (cnt_reg == CNT_LAST) begin
                    cnt_next = '0;
                    if (din_s) begin
                        dout_next    = shift_reg;
                        rx_done_next = 1'b1;
                    end else begin
                        frame_err_next = 1'b1;
                    end
                end
            end
            default: cnt_next = '0;
        endcase
    end

    assign dout      = dout_reg;
    assign rx_done   = rx_done_reg;
    assign frame_err = frame_err_reg;
    assign busy      = (state_reg != IDLE);
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: good, back-to-back, glitch, framing-error,
// mid-frame reset and loopback frames from a small transmitter model.
module tb_uart_rx;
    localparam int CPB = 16;
    localparam int DB  = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          din_r = 1'b1;
    logic          loop_en = 1'b0;
    logic          din_w;
    logic [DB-1:0] dout;
    logic          rx_done, frame_err, busy;

    // Simple 8N1 transmitter used for the loopback case.
    logic          tx_go = 1'b0;
    logic [7:0]    tx_data = 8'h00;
    logic [9:0]    tx_sh = 10'h3FF;
    logic          tx_act = 1'b0;
    int            tx_c = 0;
    int            tx_n = 0;
    logic          tx_line;

    assign tx_line = tx_act ? tx_sh[0] : 1'b1;
    assign din_w   = loop_en ? tx_line : din_r;

    uart_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB)) dut (
        .clk(clk), .rst(rst), .din(din_w),
        .dout(dout), .rx_done(rx_done), .frame_err(frame_err), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (tx_go && !tx_act) begin
            tx_sh  <= {1'b1, tx_data, 1'b0};
            tx_act <= 1'b1;
            tx_c   <= 0;
            tx_n   <= 0;
        end else if (tx_act) begin
            if (tx_c == CPB - 1) begin
                tx_c  <= 0;
                tx_sh <= {1'b1, tx_sh[9:1]};
                tx_n  <= tx_n + 1;
                if (tx_n == 9) tx_act <= 1'b0;
            end else begin
                tx_c <= tx_c + 1;
            end
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   done_cnt = 0, ferr_cnt = 0, long_cnt = 0, both_cnt = 0;
    int   done_cyc = 0, prev_done_cyc = 0;
    logic prev_done = 1'b0, prev_ferr = 1'b0, done_busy = 1'b1;
    logic [7:0] done_q[$];

    always @(negedge clk) begin
        if (rx_done) begin
            done_cnt++;
            prev_done_cyc = done_cyc;
            done_cyc      = cyc;
            done_busy     = busy;
            done_q.push_back(dout);
        end
        if (frame_err) ferr_cnt++;
        if ((rx_done && prev_done) || (frame_err && prev_ferr)) long_cnt++;
        if (rx_done && frame_err) both_cnt++;
        prev_done = rx_done;
        prev_ferr = frame_err;
    end

    int checks = 0, passes = 0, fails = 0;
    int start_cyc = 0;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_bit(input logic b);
        din_r = b;
        tick(CPB);
    endtask

    task automatic send(input logic [7:0] d, input logic stop);
        start_cyc = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(stop);
    endtask

    int d0, f0, lat;

    initial begin
        tick(3);
        check("reset_dout", int'(dout), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_strobes", int'({rx_done, frame_err}), 0);
        rst = 1'b0;
        tick(5);

        // Good frame 0xA5
        send(8'hA5, 1'b1);
        tick(4);
        lat = done_cyc - start_cyc;
        $display("txn good: dout=%02h rx_done_count=%0d latency=%0d", dout, done_cnt, lat);
        check("good_count", done_cnt, 1);
        check("good_dout", int'(dout), 8'hA5);
        check("good_latency_ok", int'(lat >= 152 && lat <= 156), 1);
        check("good_busy_falls", int'(done_busy), 0);
        check("good_no_ferr", ferr_cnt, 0);

        // Back-to-back 0x00 then 0xFF
        send(8'h00, 1'b1);
        send(8'hFF, 1'b1);
        tick(4);
        $display("txn b2b: count=%0d spacing=%0d dout=%02h", done_cnt, done_cyc - prev_done_cyc, dout);
        check("b2b_count", done_cnt, 3);
        check("b2b_spacing_ok", int'((done_cyc - prev_done_cyc) >= 159 && (done_cyc - prev_done_cyc) <= 161), 1);
        check("b2b_first", int'(done_q[1]), 8'h00);
        check("b2b_second", int'(done_q[2]), 8'hFF);
        check("b2b_dout", int'(dout), 8'hFF);

        // Start glitch, 4 cycles low
        din_r = 1'b0;
        tick(4);
        check("glitch_busy_high", int'(busy), 1);
        din_r = 1'b1;
        tick(20);
        $display("txn glitch: busy=%0d count=%0d dout=%02h", busy, done_cnt, dout);
        check("glitch_busy_low", int'(busy), 0);
        check("glitch_no_done", done_cnt, 3);
        check("glitch_dout", int'(dout), 8'hFF);

        // Framing error, line held low afterwards
        send(8'h3C, 1'b0);
        tick(300);
        check("break_busy", int'(busy), 1);
        din_r = 1'b1;
        tick(20);
        $display("txn ferr: ferr_count=%0d count=%0d dout=%02h", ferr_cnt, done_cnt, dout);
        check("ferr_count", ferr_cnt, 1);
        check("ferr_no_done", done_cnt, 3);
        check("ferr_dout", int'(dout), 8'hFF);
        send(8'h5A, 1'b1);
        tick(4);
        $display("txn after_ferr: count=%0d dout=%02h", done_cnt, dout);
        check("post_ferr_count", done_cnt, 4);
        check("post_ferr_dout", int'(dout), 8'h5A);

        // Reset during data bit 4 of 0x81
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        drive_bit(1'b0);
        drive_bit(1'b0);
        din_r = 1'b0;
        tick(8);
        check("pre_rst_busy", int'(busy), 1);
        rst = 1'b1;
        #1;
        check("rst_busy", int'(busy), 0);
        check("rst_dout", int'(dout), 0);
        check("rst_strobes", int'({rx_done, frame_err}), 0);
        tick(2);
        din_r = 1'b1;
        rst = 1'b0;
        tick(20);
        check("rst_no_done", done_cnt, 4);
        send(8'h81, 1'b1);
        tick(4);
        $display("txn rst_recover: count=%0d dout=%02h", done_cnt, dout);
        check("rst_recover_count", done_cnt, 5);
        check("rst_recover_dout", int'(dout), 8'h81);

        // Loopback with the transmitter model
        tick(10);
        loop_en = 1'b1;
        tx_data = 8'hAA;
        tx_go   = 1'b1;
        d0 = done_cnt;
        f0 = ferr_cnt;
        tick(1);
        tx_go = 1'b0;
        for (int i = 0; i < 400 && done_cnt == d0; i++) tick(1);
        tick(40);
        $display("txn loopback: count=%0d dout=%02h", done_cnt - d0, dout);
        check("loop_count", done_cnt - d0, 1);
        check("loop_dout", int'(dout), 8'hAA);
        check("loop_no_ferr", ferr_cnt - f0, 0);

        check("pulse_width", long_cnt, 0);
        check("exclusive", both_cnt, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
